// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-transaction master.
// Also holds the pad-enable decode used to register SCL/SDA drives.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        REG,
        WDATA,
        RDATA,
        STOP
    } i2c_state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

    localparam logic [3:0] ACK_BIT = 4'd8;

    // Returns {scl_low, sda_low} for a given state/quarter/bit position.
    function automatic logic [1:0] pad_oe(
        input i2c_state_t st,
        input logic [1:0] ph,
        input logic [3:0] bt,
        input logic       msb
    );
        logic scl_low;
        logic sda_low;
        scl_low = 1'b0;
        sda_low = 1'b0;
        unique case (st)
            START: begin
                scl_low = (ph == Q3);
                sda_low = ph[1];
            end
            ADDR, REG, WDATA: begin
                scl_low = (ph == Q0) || (ph == Q3);
                sda_low = (bt != ACK_BIT) && !msb;
            end
            RDATA: begin
                scl_low = (ph == Q0) || (ph == Q3);
            end
            STOP: begin
                scl_low = (ph == Q0);
                sda_low = (ph != Q3);
            end
            default: ;
        endcase
        return {scl_low, sda_low};
    endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Request/status handshake and open-drain pad bundle of the I2C master.
// The master modport is the controller side, slave is the requester/bus side.
interface i2c_master_if;

    logic        start_i;
    logic        read_i;
    logic [7:0]  slave_addr_i;
    logic [7:0]  reg_addr_i;
    logic [7:0]  data_i;
    logic [15:0] clk_div_i;
    logic        ready_o;
    logic        done_o;
    logic        nack_o;
    logic [7:0]  data_o;
    logic        scl_i;
    logic        scl_o;
    logic        scl_oe_o;
    logic        sda_i;
    logic        sda_o;
    logic        sda_oe_o;

    modport master (
        input  start_i, read_i, slave_addr_i, reg_addr_i,
        input  data_i, clk_div_i, scl_i, sda_i,
        output ready_o, done_o, nack_o, data_o,
        output scl_o, scl_oe_o, sda_o, sda_oe_o
    );

    modport slave (
        output start_i, read_i, slave_addr_i, reg_addr_i,
        output data_i, clk_div_i, scl_i, sda_i,
        input  ready_o, done_o, nack_o, data_o,
        input  scl_o, scl_oe_o, sda_o, sda_oe_o
    );

endinterface

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timebase: reloadable down-counter plus 2-bit phase.
// near_o flags the cycle before tick_o so callers can pre-register outputs.
module i2c_quarter_tick
    import i2c_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [15:0] div_i,
    output logic        tick_o,
    output logic        near_o,
    output logic [1:0]  phase_o
);

    logic [15:0] r_cnt;
    logic [1:0]  r_phase;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_phase <= Q0;
        end else if (clear_i) begin
            r_cnt   <= div_i;
            r_phase <= Q0;
        end else if (r_cnt == 16'd0) begin
            r_cnt   <= div_i;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    assign tick_o  = (r_cnt == 16'd0);
    assign near_o  = (r_cnt == 16'd1);
    assign phase_o = r_phase;

endmodule

// File: rtl/i2c_master.sv
// I2C master running one register write or single-byte read per request.
// Pad enables are registered from the next-cycle state so they align to quarters.
module i2c_master
    import i2c_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    i2c_master_if.master bus
);

    i2c_state_t  r_state;
    logic [3:0]  r_bit;
    logic [7:0]  r_sr;
    logic        r_rd;
    logic [7:0]  r_reg;
    logic [7:0]  r_wdata;
    logic [15:0] r_div;
    logic        r_nack;
    logic        r_done;
    logic        r_ready;
    logic [7:0]  r_data;
    logic        r_scl_oe;
    logic        r_sda_oe;

    logic        w_go;
    logic        w_tick;
    logic        w_near;
    logic        w_end;
    logic [1:0]  w_phase;
    logic [1:0]  w_phase_n;
    logic [15:0] w_div_ld;
    i2c_state_t  w_state_n;
    logic [3:0]  w_bit_n;
    logic [7:0]  w_sr_n;
    logic        w_nack_n;
    logic        w_scl_oe_n;
    logic        w_sda_oe_n;
    logic        w_unused;

    assign w_go     = bus.start_i && r_ready;
    assign w_div_ld = w_go ? bus.clk_div_i : r_div;
    assign w_end    = (r_state == STOP) && (w_phase == Q3) && w_near;
    assign w_unused = bus.slave_addr_i[0];

    i2c_quarter_tick u_tick (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_go),
        .div_i   (w_div_ld),
        .tick_o  (w_tick),
        .near_o  (w_near),
        .phase_o (w_phase)
    );

    always_comb begin
        w_state_n = r_state;
        w_bit_n   = r_bit;
        w_sr_n    = r_sr;
        w_nack_n  = r_nack;
        if (w_go) begin
            w_state_n = START;
            w_bit_n   = '0;
            w_sr_n    = {bus.slave_addr_i[7:1], bus.read_i};
            w_nack_n  = 1'b0;
        end else if (w_tick) begin
            unique case (r_state)
                START: begin
                    if (w_phase == Q3) w_state_n = ADDR;
                end
                ADDR, REG, WDATA: begin
                    if (w_phase == Q2 && r_bit == ACK_BIT)
                        w_nack_n = r_nack | bus.sda_i;
                    if (w_phase == Q3) begin
                        if (r_bit == ACK_BIT) begin
                            w_bit_n = '0;
                            w_sr_n  = (r_state == ADDR) ? r_reg : r_wdata;
                            if (r_nack || r_state == WDATA)
                                w_state_n = STOP;
                            else if (r_state == REG)
                                w_state_n = WDATA;
                            else
                                w_state_n = r_rd ? RDATA : REG;
                        end else begin
                            w_bit_n = r_bit + 4'd1;
                            w_sr_n  = {r_sr[6:0], 1'b0};
                        end
                    end
                end
                RDATA: begin
                    if (w_phase == Q2 && r_bit != ACK_BIT)
                        w_sr_n = {r_sr[6:0], bus.sda_i};
                    if (w_phase == Q3) begin
                        if (r_bit == ACK_BIT) begin
                            w_bit_n   = '0;
                            w_state_n = STOP;
                        end else begin
                            w_bit_n = r_bit + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_phase == Q3) w_state_n = IDLE;
                end
                default: ;
            endcase
        end
    end

    assign w_phase_n = w_go   ? Q0 :
                       w_tick ? w_phase + 2'd1 : w_phase;

    assign {w_scl_oe_n, w_sda_oe_n} =
        pad_oe(w_state_n, w_phase_n, w_bit_n, w_sr_n[7]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_bit    <= '0;
            r_sr     <= '0;
            r_rd     <= I2C_WR;
            r_reg    <= '0;
            r_wdata  <= '0;
            r_div    <= '0;
            r_nack   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
            r_data   <= '0;
            r_scl_oe <= 1'b0;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_bit    <= w_bit_n;
            r_sr     <= w_sr_n;
            r_nack   <= w_nack_n;
            r_scl_oe <= w_scl_oe_n;
            r_sda_oe <= w_sda_oe_n;
            r_done   <= w_end;
            if (w_go) begin
                r_rd    <= bus.read_i;
                r_reg   <= bus.reg_addr_i;
                r_wdata <= bus.data_i;
                r_div   <= bus.clk_div_i;
                r_ready <= 1'b0;
            end else if (w_end) begin
                // Completion is flagged one cycle early so it lands on STOP's last cycle.
                r_ready <= 1'b1;
                if (r_rd == I2C_RD) r_data <= r_sr;
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i)
        r_scl_oe |-> !bus.scl_i);

    assign bus.ready_o  = r_ready;
    assign bus.done_o   = r_done;
    assign bus.nack_o   = r_nack;
    assign bus.data_o   = r_data;
    assign bus.scl_o    = 1'b0;
    assign bus.scl_oe_o = r_scl_oe;
    assign bus.sda_o    = 1'b0;
    assign bus.sda_oe_o = r_sda_oe;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master against a behavioural register slave at 0x50.
// Table vectors cover write/read/NACK/divider; hand sequences cover reset mid-transfer.
module tb_i2c_master;

    localparam logic [6:0] S_ADDR = 7'h50;

    typedef struct {
        logic        rd;
        logic [7:0]  saddr;
        logic [7:0]  regb;
        logic [7:0]  wdat;
        logic [15:0] div;
        logic [7:0]  rdat;
        logic        poke;
        logic        exp_nack;
        logic [7:0]  exp_data;
        int          exp_cyc;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    i2c_master_if bus ();

    i2c_master dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // slave model state
    logic       s_drv;
    logic       s_prev_scl;
    logic       s_prev_sda;
    logic       s_active;
    logic       s_first;
    logic       s_rd;
    logic       s_match;
    logic       s_mack;
    logic [7:0] s_sr;
    logic [7:0] s_reg;
    logic [7:0] s_data;
    logic [7:0] s_rdata;
    int         s_bit;
    int         s_byte;
    int         n_start;
    int         n_stop;
    int         n_rise;
    logic       scl_oe_prev;
    int         falls[$];

    wire scl_w = ~bus.scl_oe_o;
    wire sda_w = ~(bus.sda_oe_o | s_drv);

    assign bus.scl_i = scl_w;
    assign bus.sda_i = sda_w;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.scl_oe_o && !scl_oe_prev) falls.push_back(cyc);
        scl_oe_prev <= bus.scl_oe_o;
    end

    always @(posedge clk) begin
        s_prev_scl <= scl_w;
        s_prev_sda <= sda_w;
        if (scl_w && s_prev_scl && s_prev_sda && !sda_w) begin
            s_active <= 1'b1;
            s_first  <= 1'b1;
            s_bit    <= 0;
            s_byte   <= 0;
            s_drv    <= 1'b0;
            s_rd     <= 1'b0;
            s_match  <= 1'b0;
            s_mack   <= 1'b0;
            s_reg    <= 8'h00;
            s_data   <= 8'h00;
            n_rise   <= 0;
            n_start  <= n_start + 1;
        end else if (scl_w && s_prev_scl && !s_prev_sda && sda_w) begin
            s_active <= 1'b0;
            s_drv    <= 1'b0;
            n_stop   <= n_stop + 1;
        end else if (s_active && scl_w && !s_prev_scl) begin
            n_rise <= n_rise + 1;
            if (s_bit < 8) s_sr <= {s_sr[6:0], sda_w};
            else if (s_rd && s_byte == 1) s_mack <= sda_w;
        end else if (s_active && !scl_w && s_prev_scl) begin
            if (s_first) begin
                s_first <= 1'b0;
            end else if (s_bit == 7) begin
                s_bit <= 8;
                if (s_rd && s_byte == 1) begin
                    s_drv <= 1'b0;
                end else if (s_byte == 0) begin
                    s_match <= (s_sr[7:1] == S_ADDR);
                    s_drv   <= (s_sr[7:1] == S_ADDR);
                    s_rd    <= s_sr[0];
                end else begin
                    s_drv <= 1'b1;
                    if (s_byte == 1) s_reg <= s_sr;
                    else s_data <= s_sr;
                end
            end else if (s_bit == 8) begin
                s_bit  <= 0;
                s_byte <= s_byte + 1;
                if (!s_match) begin
                    s_active <= 1'b0;
                    s_drv    <= 1'b0;
                end else if (s_rd && s_byte == 0) begin
                    s_drv <= !s_rdata[7];
                end else begin
                    s_drv <= 1'b0;
                end
            end else begin
                s_bit <= s_bit + 1;
                if (s_rd && s_byte == 1) s_drv <= !s_rdata[6 - s_bit];
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, req, req);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int   acc;
        int   ss;
        int   sp;
        int   per;
        bit   got;
        bit   busy_bad;
        logic nk;
        logic [7:0] dat;
        @(negedge clk);
        ss       = n_start;
        sp       = n_stop;
        s_rdata  = v.rdat;
        busy_bad = 1'b0;
        got      = 1'b0;
        falls.delete();
        bus.start_i      = 1'b1;
        bus.read_i       = v.rd;
        bus.slave_addr_i = v.saddr;
        bus.reg_addr_i   = v.regb;
        bus.data_i       = v.wdat;
        bus.clk_div_i    = v.div;
        acc = cyc;
        @(negedge clk);
        bus.start_i      = 1'b0;
        bus.read_i       = 1'b0;
        bus.slave_addr_i = 8'hA0;
        bus.reg_addr_i   = 8'hEE;
        bus.data_i       = 8'h11;
        bus.clk_div_i    = 16'd9;
        for (int i = 0; i < 2000; i++) begin
            if (bus.done_o) begin
                got = 1'b1;
                break;
            end
            if (bus.ready_o) busy_bad = 1'b1;
            bus.start_i = v.poke && (i == 100);
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        if (!got) begin
            chk({tag, "_done_timeout"}, 0, 1);
            return;
        end
        nk  = bus.nack_o;
        dat = bus.data_o;
        chk({tag, "_latency"}, cyc - acc, v.exp_cyc);
        chk({tag, "_nack"}, int'(nk), int'(v.exp_nack));
        chk({tag, "_ready_at_done"}, int'(bus.ready_o), 1);
        chk({tag, "_busy_ready_low"}, int'(busy_bad), 0);
        chk({tag, "_start_count"}, n_start - ss, 1);
        chk({tag, "_stop_seen"}, n_stop - sp, 1);
        per = (falls.size() >= 3) ? falls[2] - falls[1] : -1;
        chk({tag, "_scl_period"}, per, 4 * (int'(v.div) + 1));
        if (v.exp_nack) begin
            chk({tag, "_rises"}, n_rise, 9);
        end else if (v.rd) begin
            chk({tag, "_rdata"}, int'(dat), int'(v.exp_data));
            chk({tag, "_master_nack_bit"}, int'(s_mack), 1);
        end else begin
            chk({tag, "_slave_reg"}, int'(s_reg), int'(v.regb));
            chk({tag, "_slave_data"}, int'(s_data), int'(v.wdat));
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(bus.done_o), 0);
    endtask

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bit   hit;
        bit   saw_done;
        cyc = 0; checks = 0; errors = 0;
        n_start = 0; n_stop = 0; n_rise = 0;
        s_drv = 1'b0; s_active = 1'b0; s_first = 1'b0;
        s_prev_scl = 1'b1; s_prev_sda = 1'b1;
        s_rd = 1'b0; s_match = 1'b0; s_mack = 1'b0;
        s_sr = 8'h00; s_reg = 8'h00; s_data = 8'h00; s_rdata = 8'h00;
        s_bit = 0; s_byte = 0; scl_oe_prev = 1'b0;
        bus.start_i = 1'b0; bus.read_i = 1'b0;
        bus.slave_addr_i = 8'h00; bus.reg_addr_i = 8'h00;
        bus.data_i = 8'h00; bus.clk_div_i = 16'd4;

        //          rd    saddr  reg    wdat   div    rdat   poke  nack  data   cycles
        vecs[0] = '{1'b0, 8'hA0, 8'h12, 8'hA5, 16'd4, 8'h00, 1'b0, 1'b0, 8'h00, 580};
        vecs[1] = '{1'b1, 8'hA0, 8'h00, 8'h00, 16'd4, 8'h3C, 1'b0, 1'b0, 8'h3C, 400};
        vecs[2] = '{1'b0, 8'h44, 8'h12, 8'hA5, 16'd4, 8'h00, 1'b0, 1'b1, 8'h00, 220};
        vecs[3] = '{1'b0, 8'hA0, 8'h12, 8'hA5, 16'd3, 8'h00, 1'b0, 1'b0, 8'h00, 464};
        vecs[4] = '{1'b1, 8'hA0, 8'h00, 8'h00, 16'd3, 8'hC3, 1'b0, 1'b0, 8'hC3, 320};
        vecs[5] = '{1'b0, 8'hA0, 8'h34, 8'h5A, 16'd4, 8'h00, 1'b1, 1'b0, 8'h00, 580};
        vecs[6] = '{1'b1, 8'h44, 8'h00, 8'h00, 16'd3, 8'h00, 1'b0, 1'b1, 8'h00, 176};
        vecs[7] = '{1'b0, 8'hA1, 8'h7E, 8'h81, 16'd5, 8'h00, 1'b0, 1'b0, 8'h00, 696};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(bus.ready_o), 1);
        chk("rst_done", int'(bus.done_o), 0);
        chk("rst_nack", int'(bus.nack_o), 0);
        chk("rst_data", int'(bus.data_o), 0);
        chk("rst_scl_oe", int'(bus.scl_oe_o), 0);
        chk("rst_sda_oe", int'(bus.sda_oe_o), 0);

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
            repeat (5) @(negedge clk);
        end

        // Reset during the register byte, then a clean write afterwards.
        @(negedge clk);
        bus.start_i = 1'b1; bus.read_i = 1'b0;
        bus.slave_addr_i = 8'hA0; bus.reg_addr_i = 8'h77;
        bus.data_i = 8'h88; bus.clk_div_i = 16'd4;
        @(negedge clk);
        bus.start_i = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (s_byte == 1 && s_bit == 3) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_reg_reached", int'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_scl_oe", int'(bus.scl_oe_o), 0);
        chk("mid_sda_oe", int'(bus.sda_oe_o), 0);
        chk("mid_ready", int'(bus.ready_o), 1);
        chk("mid_done", int'(bus.done_o), 0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done_o) saw_done = 1'b1;
        end
        chk("mid_no_done", int'(saw_done), 0);
        v = '{1'b0, 8'hA0, 8'hC5, 8'h3A, 16'd4, 8'h00, 1'b0, 1'b0, 8'h00, 580};
        run_vec("post_rst", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
# i2c_master

I2C initiator for the peripheral subsystem, the bus-side counterpart of the existing I2C slave register port. On a single start request it runs one complete register transaction and returns a one-cycle completion pulse with status and read data. A write is START, address+W, register byte, data byte, STOP. A read is START, address+R, one data byte, master NACK, STOP. Both SCL and SDA are open-drain, with a low driven through the output enables.

## Interface
Parameters:
- none. Bus speed is set at runtime through `clk_div_i`.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `start_i` in 1: transaction request. It is accepted only when `ready_o`=1.
- `read_i` in 1: 1 selects a read transaction, 0 selects a write.
- `slave_addr_i` in 8: bits [7:1] are the 7-bit target address. Bit 0 is ignored and replaced by `read_i`.
- `reg_addr_i` in 8: register byte, used by writes only.
- `data_i` in 8: write data byte.
- `clk_div_i` in 16: quarter-period length minus 1, so Q = `clk_div_i`+1 cycles. Legal range is ≥ 3.
- `ready_o` out 1: idle, able to accept `start_i`.
- `done_o` out 1: one-cycle pulse at the end of every transaction.
- `nack_o` out 1: status, valid with `done_o`. Set to 1 when any address/register/data byte was NACKed.
- `data_o` out 8: read byte, valid from `done_o` until the next accepted start.
- `scl_i`, `scl_o`, `scl_oe_o`: SCL pad. `scl_o` is tied to 0, and `scl_oe_o`=1 pulls SCL low.
- `sda_i`, `sda_o`, `sda_oe_o`: SDA pad. `sda_o` is tied to 0, and `sda_oe_o`=1 pulls SDA low.

## Operation
- **Reset values:** `ready_o`=1, `done_o`=0, `nack_o`=0, `data_o`=0x00, `scl_oe_o`=0, `sda_oe_o`=0. State is IDLE.
- **Accept:** in the cycle where `start_i`&&`ready_o`, latch `read_i`, `slave_addr_i`, `reg_addr_i`, `data_i` and `clk_div_i`. `ready_o` drops the next cycle and `nack_o` clears. Changes to the inputs after this cycle have no effect.
- **`start_i` while busy:** ignored, with no queueing.
- **Bit timing:** every bit is 4 quarters of Q cycles each.
  - q0: SCL low, SDA updated.
  - q1 and q2: SCL released (high).
  - q3: SCL low.
  - Sample `sda_i` in the last cycle of q2.
- **State machine:** IDLE → START → ADDR → (write: REG → WDATA | read: RDATA) → STOP → IDLE.
- **START:** 4 quarters.
  - q0–q1: both lines released.
  - q2: SDA low with SCL high.
  - q3: SCL low.
- **Byte states (ADDR, REG, WDATA):** 9 bits.
  - Bits 1–8 shift MSB first. A bit value of 1 releases SDA, a 0 pulls it low.
  - Bit 9 releases SDA and samples the ACK, where 0 = ACK.
- **ACK check:** a 1 on bit 9 sets `nack_o` and jumps straight to STOP, skipping the remaining bytes.
- **RDATA:** 9 bits.
  - Bits 1–8: SDA released, `sda_i` shifted in MSB first.
  - Bit 9: SDA released (master NACK, last byte).
  - `data_o` updates at `done_o`.
- **STOP:** 4 quarters.
  - q0: SDA low, SCL low.
  - q1–q2: SCL high, SDA still low.
  - q3: SDA released while SCL is high.
- **End of STOP:** `done_o`=1 for one cycle, `ready_o`=1 in the same cycle, and the state returns to IDLE.
- **Clock stretching and arbitration:** not supported. `scl_i` is unused except for assertions.

## Timing
- **Write latency:** with no NACK, (4 + 27×4 + 4)·Q = 116·Q cycles, counted from the cycle after accept to the cycle `done_o` is high inclusive.
- **Read latency:** (4 + 18×4 + 4)·Q = 80·Q cycles.
- **Address NACK:** (4 + 9×4 + 4)·Q = 44·Q cycles.
- **Quarter counter:**
  - 16-bit down-counter, loaded with `clk_div_i` at each quarter start; it advances the phase on reaching 0.
  - 2-bit phase counter.
  - 4-bit bit counter that wraps 8→0 at the byte boundary, i.e. counts 0..8.
- **Reset mid-transaction:** both OEs release in the cycle after `rst_i`, with no STOP generated and no `done_o`.
- **Slave timing margin:** Q ≥ 4 gives a slave with a 2-flop edge detector time to drive ACK/data before the q2 sample.

## Structure
- **Package `i2c_pkg`:**
  - state enum: IDLE, START, ADDR, REG, WDATA, RDATA, STOP
  - phase constants Q0–Q3
  - `I2C_RD`=1, `I2C_WR`=0
- **Sub-module `i2c_quarter_tick`:** loadable down-counter. Outputs `tick_o` at each quarter end and `phase_o[1:0]`. It restarts on `clear_i`.
- **`i2c_master`:** the FSM, shift register and bit counter.

## Test plan
- **Write:** addr 0x50, reg 0x12, data 0xA5, Q=5 (`clk_div_i`=4), against the i2c_slave instance at 0x50.
  - Slave `addr_o`=0x12 and `data_o`=0xA5 with `valid_o`.
  - `done_o` exactly 580 cycles after accept.
  - `nack_o`=0.
- **Read:** addr 0x50, slave `data_i`=0x3C.
  - `data_o`=0x3C and `nack_o`=0 at `done_o`.
  - Duration 400 cycles.
  - SDA released on the 9th bit.
- **Address NACK:** target 0x22 with the slave at 0x50.
  - `nack_o`=1 after 44·Q cycles.
  - No REG byte clocked.
  - STOP seen (SDA rises while SCL high).
- **Busy request:** `start_i` pulsed with different data during a write is ignored. `ready_o`=0 throughout, and only the original bytes appear.
- **Reset mid-transaction:** assert `rst_i` during the REG byte.
  - Next cycle: `scl_oe_o`=`sda_oe_o`=0 and `ready_o`=1, with no `done_o`.
  - A new write then completes normally.
- **Minimum divider:** run the write case at `clk_div_i`=3. It must pass with an SCL period of exactly 16 cycles.
